// File: rtl/pipe_hazard_ctrl.sv
// Control pipeline (D->E->M->W) and hazard unit for the 5-stage RV32I core.
// Produces stall/flush/forward/PC-select controls plus saturating event counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write_d,
    input  logic [1:0]            result_src_d,
    input  logic                  mem_write_d,
    input  logic                  branch_d,
    input  logic                  jump_d,
    input  logic                  alu_src_d,
    input  logic [ALU_CTRL_W-1:0] alu_control_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  zero_e,
    output logic                  alu_src_e,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  mem_write_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic                  pc_src_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic                  r_reg_write_e;
    logic [1:0]            r_result_src_e;
    logic                  r_mem_write_e;
    logic                  r_branch_e;
    logic                  r_jump_e;
    logic                  r_alu_src_e;
    logic [ALU_CTRL_W-1:0] r_alu_control_e;
    logic [REG_ADDR_W-1:0] r_rs1_e;
    logic [REG_ADDR_W-1:0] r_rs2_e;
    logic [REG_ADDR_W-1:0] r_rd_e;

    logic                  r_reg_write_m;
    logic [1:0]            r_result_src_m;
    logic                  r_mem_write_m;
    logic [REG_ADDR_W-1:0] r_rd_m;

    logic                  r_reg_write_w;
    logic [1:0]            r_result_src_w;
    logic [REG_ADDR_W-1:0] r_rd_w;

    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic                  w_lw_stall;
    logic                  w_pc_src;
    logic                  w_flush_e;
    logic [1:0]            w_fwd_a;
    logic [1:0]            w_fwd_b;

    assign w_pc_src   = r_jump_e | (r_branch_e & zero_e);
    // Uses only registered E state and D addresses: no path from zero_e.
    assign w_lw_stall = (r_result_src_e == 2'b01) && (r_rd_e != '0) &&
                        ((rs1_d == r_rd_e) || (rs2_d == r_rd_e));
    assign w_flush_e  = w_lw_stall | w_pc_src;

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_reg_write_m && (r_rd_m != '0) && (r_rs1_e == r_rd_m))
            w_fwd_a = 2'b10;
        else if (r_reg_write_w && (r_rd_w != '0) && (r_rs1_e == r_rd_w))
            w_fwd_a = 2'b01;
        if (r_reg_write_m && (r_rd_m != '0) && (r_rs2_e == r_rd_m))
            w_fwd_b = 2'b10;
        else if (r_reg_write_w && (r_rd_w != '0) && (r_rs2_e == r_rd_w))
            w_fwd_b = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write_e   <= 1'b0;
            r_result_src_e  <= 2'b00;
            r_mem_write_e   <= 1'b0;
            r_branch_e      <= 1'b0;
            r_jump_e        <= 1'b0;
            r_alu_src_e     <= 1'b0;
            r_alu_control_e <= '0;
            r_rs1_e         <= '0;
            r_rs2_e         <= '0;
            r_rd_e          <= '0;
        end else if (w_flush_e) begin
            r_reg_write_e   <= 1'b0;
            r_result_src_e  <= 2'b00;
            r_mem_write_e   <= 1'b0;
            r_branch_e      <= 1'b0;
            r_jump_e        <= 1'b0;
            r_alu_src_e     <= 1'b0;
            r_alu_control_e <= '0;
            r_rs1_e         <= '0;
            r_rs2_e         <= '0;
            r_rd_e          <= '0;
        end else begin
            r_reg_write_e   <= reg_write_d;
            r_result_src_e  <= result_src_d;
            r_mem_write_e   <= mem_write_d;
            r_branch_e      <= branch_d;
            r_jump_e        <= jump_d;
            r_alu_src_e     <= alu_src_d;
            r_alu_control_e <= alu_control_d;
            r_rs1_e         <= rs1_d;
            r_rs2_e         <= rs2_d;
            r_rd_e          <= rd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_mem_write_m  <= 1'b0;
            r_rd_m         <= '0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 2'b00;
            r_rd_w         <= '0;
        end else begin
            r_reg_write_m  <= r_reg_write_e;
            r_result_src_m <= r_result_src_e;
            r_mem_write_m  <= r_mem_write_e;
            r_rd_m         <= r_rd_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
            r_rd_w         <= r_rd_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lw_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_pc_src && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // One instruction in E cannot be both a load and a taken branch/jump.
    a_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_lw_stall && w_pc_src));

    assign alu_src_e     = r_alu_src_e;
    assign alu_control_e = r_alu_control_e;
    assign mem_write_m   = r_mem_write_m;
    assign reg_write_w   = r_reg_write_w;
    assign result_src_w  = r_result_src_w;
    assign rd_w          = r_rd_w;
    assign pc_src_e      = w_pc_src;
    assign stall_f       = w_lw_stall;
    assign stall_d       = w_lw_stall;
    assign flush_d       = w_pc_src;
    assign flush_e       = w_flush_e;
    assign forward_a_e   = w_fwd_a;
    assign forward_b_e   = w_fwd_b;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (4-bit counters to reach saturation).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic       mem_write_d;
    logic       branch_d;
    logic       jump_d;
    logic       alu_src_d;
    logic [2:0] alu_control_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       zero_e;
    logic       alu_src_e;
    logic [2:0] alu_control_e;
    logic       mem_write_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic [4:0] rd_w;
    logic       pc_src_e;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .ALU_CTRL_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_write_d(reg_write_d), .result_src_d(result_src_d),
        .mem_write_d(mem_write_d), .branch_d(branch_d), .jump_d(jump_d),
        .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .zero_e(zero_e),
        .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
        .mem_write_m(mem_write_m), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .rd_w(rd_w), .pc_src_e(pc_src_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .flush_e(flush_e), .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic rw, input logic [1:0] rs,
                         input logic mw, input logic br, input logic jp,
                         input logic as, input logic [2:0] ac,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] ad);
        reg_write_d = rw; result_src_d = rs; mem_write_d = mw;
        branch_d = br; jump_d = jp; alu_src_d = as; alu_control_d = ac;
        rs1_d = a1; rs2_d = a2; rd_d = ad;
        #1;
    endtask

    task automatic nop();
        set_d(0, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    logic [3:0] s0;
    logic [3:0] f0;

    initial begin
        rst_n  = 1'b0;
        zero_e = 1'b0;
        nop();
        #2;
        check("rst_pc_src", pc_src_e, 0);
        check("rst_stall_f", stall_f, 0);
        check("rst_flush_e", flush_e, 0);
        check("rst_fwd_a", forward_a_e, 0);
        check("rst_reg_write_w", reg_write_w, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // add x5 ; sub x7,x5,x3 -> M forward
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd1, 5'd5, 5'd3, 5'd7);
        check("alu_ctrl_e_add", alu_control_e, 0);
        tick();
        check("fwd_a_m", forward_a_e, 2'b10);
        check("fwd_b_none", forward_b_e, 2'b00);
        check("alu_ctrl_e_sub", alu_control_e, 1);

        // add x5 ; add x8 ; sub rs1=x5 -> W forward
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd8);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd1, 5'd5, 5'd8, 5'd7);
        tick();
        check("fwd_a_w", forward_a_e, 2'b01);
        check("fwd_b_m", forward_b_e, 2'b10);

        // add x5 ; add x5 ; sub rs1=x5 -> M beats W
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        tick();
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd1, 5'd5, 5'd5, 5'd7);
        tick();
        check("fwd_a_m_prio", forward_a_e, 2'b10);
        check("fwd_b_m_prio", forward_b_e, 2'b10);

        // lw x6 ; add x9,x1,x6 -> one stall cycle
        set_d(1, 2'b01, 0, 0, 0, 1, 3'd0, 5'd1, 5'd0, 5'd6);
        tick();
        check("lw_alu_src_e", alu_src_e, 1);
        s0 = stall_cnt;
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd6, 5'd9);
        check("lu_stall_f", stall_f, 1);
        check("lu_stall_d", stall_d, 1);
        check("lu_flush_e", flush_e, 1);
        check("lu_flush_d", flush_d, 0);
        tick();
        check("lu_stall_cleared", stall_f, 0);
        check("lu_bubble_alu_src", alu_src_e, 0);
        check("lu_stall_cnt", stall_cnt, s0 + 4'd1);
        tick();
        check("lu_fwd_b_w", forward_b_e, 2'b01);
        check("lu_fwd_a_none", forward_a_e, 2'b00);

        // store reaches M after two edges
        set_d(0, 2'b00, 1, 0, 0, 1, 3'd0, 5'd1, 5'd2, 5'd0);
        tick();
        nop();
        check("sw_not_m_yet", mem_write_m, 0);
        tick();
        check("sw_mem_write_m", mem_write_m, 1);

        // beq taken
        set_d(0, 2'b00, 0, 1, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0);
        tick();
        nop();
        zero_e = 1'b1;
        #1;
        f0 = flush_cnt;
        check("beq_t_pc_src", pc_src_e, 1);
        check("beq_t_flush_d", flush_d, 1);
        check("beq_t_flush_e", flush_e, 1);
        check("beq_t_stall_f", stall_f, 0);
        tick();
        check("beq_t_one_cycle", pc_src_e, 0);
        check("beq_t_flush_cnt", flush_cnt, f0 + 4'd1);

        // beq not taken
        set_d(0, 2'b00, 0, 1, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0);
        tick();
        nop();
        zero_e = 1'b0;
        #1;
        check("beq_nt_pc_src", pc_src_e, 0);
        check("beq_nt_flush_d", flush_d, 0);
        check("beq_nt_flush_e", flush_e, 0);

        // jal x1 taken regardless of zero_e
        set_d(1, 2'b10, 0, 0, 1, 0, 3'd0, 5'd0, 5'd0, 5'd1);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd2, 5'd3, 5'd4);
        check("jal_pc_src", pc_src_e, 1);
        check("jal_flush_e", flush_e, 1);
        tick();
        nop();
        tick();
        check("jal_rd_w", rd_w, 1);
        check("jal_result_src_w", result_src_w, 2'b10);
        check("jal_reg_write_w", reg_write_w, 1);

        // lw x0 then add rs1=x0 -> no stall
        set_d(1, 2'b01, 0, 0, 0, 1, 3'd0, 5'd1, 5'd0, 5'd0);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd3);
        check("x0_no_stall", stall_f, 0);
        check("x0_no_flush_e", flush_e, 0);
        // add x0 then add rs1=x0 -> no forward
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd0);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd3);
        tick();
        check("x0_fwd_a", forward_a_e, 2'b00);
        check("x0_fwd_b", forward_b_e, 2'b00);

        // repeated lw x6 with rs1=x6: a stall every other cycle
        set_d(1, 2'b01, 0, 0, 0, 1, 3'd0, 5'd6, 5'd0, 5'd6);
        for (int i = 0; i < 40; i++) tick();
        check("sat_stall_cnt", stall_cnt, 4'd15);
        for (int i = 0; i < 4; i++) tick();
        check("sat_hold", stall_cnt, 4'd15);

        // async reset while a taken branch sits in E
        set_d(0, 2'b00, 0, 1, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0);
        tick();
        zero_e = 1'b1;
        nop();
        check("pre_rst_pc_src", pc_src_e, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc_src", pc_src_e, 0);
        check("mid_rst_flush_d", flush_d, 0);
        check("mid_rst_flush_e", flush_e, 0);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_flush_cnt", flush_cnt, 0);
        check("mid_rst_fwd_a", forward_a_e, 0);
        zero_e = 1'b0;
        set_d(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_w_bubble1", reg_write_w, 0);
        tick();
        check("post_rst_w_bubble2", reg_write_w, 0);
        tick();
        check("post_rst_w_add", reg_write_w, 1);
        check("post_rst_rd_w", rd_w, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
